// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states, RAM depth.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam int RAM_WORDS_DEFAULT = 10001;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_t;

   // True when the size code is illegal or the byte offset is not naturally aligned for it.
   function automatic logic size_align_bad(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return (off != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mau_lane.sv
// Lane steering: merges store data into a word and extracts/extends load data from it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module mau_lane
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] merged,
   output logic [31:0] extracted
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Little-endian lanes: byte n at [8n+7:8n], halfword selected by addr[1].
   assign byte_lane = word[{addr, 3'b000} +: 8];
   assign half_lane = word[{addr[1], 4'b0000} +: 16];

   // Replace only the addressed lanes on stores; extend the addressed lane on loads.
   always_comb begin
      merged    = word;
      extracted = '0;
      case (size)
         SZ_BYTE: begin
            merged[{addr, 3'b000} +: 8] = wdata[7:0];
            extracted = {{24{sign_ext & byte_lane[7]}}, byte_lane};
         end
         SZ_HALF: begin
            merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            extracted = {{16{sign_ext & half_lane[15]}}, half_lane};
         end
         SZ_WORD: begin
            merged    = wdata;
            extracted = word;
         end
         default: begin
            merged    = word;
            extracted = '0;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store front end to a word RAM with sub-word read-modify-write and error screening.
// Latency accept->rsp_valid: error 1, load 2, word store 2, sub-word store 3 cycles.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int RAM_WORDS = RAM_WORDS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        ram_wena,
   output logic        ram_rena,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   localparam logic [31:0] WORD_LIMIT = 32'(RAM_WORDS);

   state_t      state_q;
   state_t      state_d;
   logic        accept;
   logic        req_err;
   logic [31:0] req_index;

   logic        we_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] word_q;

   logic [31:0] merged;
   logic [31:0] extracted;

   assign req_index = {2'b00, req_addr[31:2]};

   // Word 0 is write-protected; everything else is range and alignment screening.
   assign req_err = size_align_bad(req_size, req_addr[1:0])
                  | (req_index >= WORD_LIMIT)
                  | (req_we & (req_index == 32'd0));

   mau_lane u_lane (
      .word      (word_q),
      .wdata     (wdata_q),
      .addr      (addr_q[1:0]),
      .size      (size_q),
      .sign_ext  (sign_q),
      .merged    (merged),
      .extracted (extracted)
   );

   // State register; reset drops any in-flight request and kills a pending RAM write at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and all outputs; RAM strobes exist only in RD/WR, response only in RESP.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      ram_wena  = 1'b0;
      ram_rena  = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state_q)
         IDLE: begin
            // Gated by rst_n so ready stays low for the whole reset pulse.
            req_ready = rst_n;
            accept    = req_valid & rst_n;
            if (accept) begin
               if (req_err) begin
                  state_d = RESP;
               end else if (!req_we) begin
                  state_d = RD;
               end else if (req_size == SZ_WORD) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            ram_rena = 1'b1;
            ram_addr = {2'b00, addr_q[31:2]};
            state_d  = we_q ? WR : RESP;
         end
         WR: begin
            ram_wena  = 1'b1;
            ram_addr  = {2'b00, addr_q[31:2]};
            ram_wdata = merged;
            state_d   = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = (err_q | we_q) ? 32'd0 : extracted;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture on accept; RAM word captured only at the end of RD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sign_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         word_q  <= '0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sign_q  <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
         end
         if (state_q == RD) begin
            word_q <= ram_rdata;
         end
      end
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: RAM_WORDS, 10001, number of addressable 32-bit words in the downstream RAM.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  CPU request valid.
REQ-005 SHALL have port: req_ready  output  1  unit accepts request this cycle.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port: req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port: req_addr  input  32  byte address.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port: rsp_valid  output  1  response valid.
REQ-012 SHALL have port: rsp_ready  input  1  CPU accepts response.
REQ-013 SHALL have port: rsp_rdata  output  32  load result, extended.
REQ-014 SHALL have port: rsp_err  output  1  request rejected, no RAM write.
REQ-015 SHALL have ports to the word RAM: ram_wena out 1, ram_rena out 1, ram_addr out 32 (word index), ram_wdata out 32, ram_rdata in 32 (combinational read, Z when rena=0; write on clk edge when wena=1).

Function
REQ-016 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL on req_valid&req_ready latch all req_* fields; word index = req_addr[31:2].
REQ-018 SHALL flag error when: size=11; size=01 and addr[0]=1; size=10 and addr[1:0]!=0; word index >= RAM_WORDS; store to word index 0.
REQ-019 SHALL on error go IDLE->RESP directly, rsp_err=1, rsp_rdata=0, no ram_rena/ram_wena pulse.
REQ-020 SHALL for loads: IDLE->RD->RESP; RD drives ram_rena=1, ram_addr=index, captures ram_rdata at end of RD.
REQ-021 SHALL for word stores: IDLE->WR->RESP; WR drives ram_wena=1, ram_wdata=req_wdata for exactly one cycle.
REQ-022 SHALL for byte/halfword stores: IDLE->RD->WR->RESP; WR writes captured word with only the addressed lanes replaced (read-modify-write).
REQ-023 SHALL use little-endian lanes: byte n occupies bits [8n+7:8n], n=addr[1:0]; halfword at addr[1]=1 occupies [31:16].
REQ-024 SHALL extract load lanes and zero-extend (req_signed=0) or sign-extend from lane MSB (req_signed=1); word loads ignore req_signed.
REQ-025 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1, then return to IDLE; next request accepted no earlier than the following cycle.
REQ-026 SHALL drive ram_rena=0, ram_wena=0 outside RD/WR; ram_rdata SHALL never be sampled outside RD.
REQ-027 SHALL have latency request-accept to rsp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-028 SHALL give rsp_rdata=0 for stores.

Reset
REQ-029 SHALL on rst_n=0 immediately force state IDLE and all outputs 0 (req_ready becomes 1 after rst_n releases).
REQ-030 SHALL drop any in-flight request on reset; a reset asserted during WR SHALL deassert ram_wena asynchronously so no write occurs at the next edge.

Structure
REQ-031 SHALL place size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state type and default RAM_WORDS in shared package mem_pkg.
REQ-032 SHALL put lane merge and load extraction in one combinational sub-module mau_lane (inputs word, wdata, addr[1:0], size, signed; outputs merged word, extracted data).

Verification
REQ-033 SHALL check: word[5]=32'h11223344, load byte addr 0x15 signed=0 -> rsp_rdata=32'h00000033, latency 2.
REQ-034 SHALL check: word[5]=32'h11223384, load byte addr 0x14 signed=1 -> rsp_rdata=32'hFFFFFF84.
REQ-035 SHALL check: word[5]=32'h11223344, store half 0xBEEF at addr 0x16 -> word[5]=32'hBEEF3344, one ram_wena pulse, latency 3.
REQ-036 SHALL check: load word addr 0x6 -> rsp_err=1, rsp_rdata=0, no ram_rena; store word addr 0x0 -> rsp_err=1, no ram_wena.
REQ-037 SHALL check: rsp_ready held 0 for 4 cycles -> rsp_* stable, req_ready=0 throughout.
REQ-038 SHALL check: rst_n asserted during WR of store 0xA5A5A5A5 to word 7 -> word 7 unchanged, outputs 0 immediately, next load completes normally.
